// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks into one register-file
// write port, with a per-register pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [2:0]        alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [2:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              rsv_valid,
  input  logic [2:0]        rsv_dest,
  output logic [7:0]        wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        busy
);

  // prio_mem_q=1: MEM wins the next conflict
  logic              prio_mem_q, prio_mem_d;
  logic [7:0]        wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]        busy_q, busy_d;

  logic              alu_gnt;
  logic              mem_gnt;
  logic              xfer;
  logic [2:0]        x_dest;
  logic [DATA_W-1:0] x_data;

  always_comb begin
    alu_gnt = rst_n & alu_valid & (~mem_valid | ~prio_mem_q);
    mem_gnt = rst_n & mem_valid & (~alu_valid | prio_mem_q);
    xfer    = alu_gnt | mem_gnt;
    x_dest  = alu_gnt ? alu_dest : mem_dest;
    x_data  = alu_gnt ? alu_data : mem_data;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_comb begin
    prio_mem_d = prio_mem_q;
    wr_en_d    = 8'h00;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    if (xfer) begin
      prio_mem_d       = alu_gnt;
      wr_en_d[x_dest]  = 1'b1;
      wr_data_d        = x_data;
      busy_d[x_dest]   = 1'b0;
    end
    // set after clear: a fresh reservation outlives the older write
    if (rsv_valid) begin
      busy_d[rsv_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_mem_q <= 1'b0;
      wr_en_q    <= 8'h00;
      wr_data_q  <= '0;
      busy_q     <= 8'h00;
    end else begin
      prio_mem_q <= prio_mem_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule
